// File: rtl/contreg_seq_pkg.sv
// Shared types and constants for the contreg micro-sequencer: state encoding,
// instruction word layout and the counter's operation request codes.
package contreg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int INSTR_W   = 12;
    localparam int OP_MSB    = 11;
    localparam int OP_LSB    = 9;
    localparam int UNTIL_BIT = 8;
    localparam int ARG_MSB   = 7;
    localparam int ARG_LSB   = 4;
    localparam int CNT_MSB   = 3;
    localparam int CNT_LSB   = 0;

    // Request line index on the counter/register block
    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_UP   = 3'd2;
    localparam logic [2:0] OP_DOWN = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_ROTL = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] op);
        return 8'b0000_0001 << op;
    endfunction

endpackage

// File: rtl/contreg_seq_store.sv
// Instruction store: DEPTH x 12-bit register file, synchronous write and
// combinational read. Contents are deliberately not reset.
module contreg_seq_store
    import contreg_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/contreg_seq.sv
// Micro-sequencer driving the counter/register block's one-hot request lines
// and load value from a programmable instruction store.
module contreg_seq
    import contreg_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [AW-1:0]      prog_last,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [3:0]         q_in,
    output logic [7:0]         op_sel,
    output logic [3:0]         e_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      pc
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      w_pc_nxt;
    logic [AW-1:0]      r_last_q;
    logic [AW-1:0]      w_last_q_nxt;
    logic [3:0]         r_rep;
    logic [3:0]         w_rep_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic [INSTR_W-1:0] w_instr;
    logic [2:0]         w_op;
    logic               w_until;
    logic [3:0]         w_arg;
    logic [3:0]         w_cnt;
    logic               w_match;
    logic               w_rep_hit;
    logic               w_last_slot;
    logic               w_advance;
    logic               w_we;

    assign w_we = prog_we && (r_state == ST_IDLE);

    contreg_seq_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_instr)
    );

    assign w_op        = w_instr[OP_MSB:OP_LSB];
    assign w_until     = w_instr[UNTIL_BIT];
    assign w_arg       = w_instr[ARG_MSB:ARG_LSB];
    assign w_cnt       = w_instr[CNT_MSB:CNT_LSB];
    assign w_match     = w_until && (q_in == w_arg);
    assign w_rep_hit   = (r_rep == w_cnt);
    assign w_last_slot = (r_pc == r_last_q);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_last_q <= '0;
            r_rep    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_last_q <= w_last_q_nxt;
            r_rep    <= w_rep_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_last_q_nxt = r_last_q;
        w_rep_nxt    = r_rep;
        w_err_nxt    = r_err;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt  = ST_ISSUE;
                    w_pc_nxt     = '0;
                    w_rep_nxt    = '0;
                    w_err_nxt    = 1'b0;
                    w_last_q_nxt = prog_last;
                end
            end
            ST_ISSUE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // A match takes precedence over the timeout on the same cycle
                    if (w_until) begin
                        if (w_match) begin
                            w_advance = 1'b1;
                        end else if (w_rep_hit) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_rep_nxt = r_rep + 4'd1;
                        end
                    end else begin
                        if (w_rep_hit) begin
                            w_advance = 1'b1;
                        end else begin
                            w_rep_nxt = r_rep + 4'd1;
                        end
                    end
                    if (w_advance) begin
                        w_rep_nxt = '0;
                        if (!w_last_slot) begin
                            w_pc_nxt = r_pc + 1'b1;
                        end else if (loop_en) begin
                            w_pc_nxt = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        op_sel = 8'h00;
        e_out  = 4'h0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                busy   = 1'b1;
                e_out  = w_arg;
                op_sel = w_match ? 8'h00 : onehot8(w_op);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err = r_err;
    assign pc  = r_pc;

endmodule

// File: tb/tb_contreg_seq.sv
// Self-checking bench for contreg_seq: a program-level interpreter with a
// behavioural counter predicts every cycle of outputs for directed and random programs.
module tb_contreg_seq;
    import contreg_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [11:0]   prog_data;
    logic [AW-1:0] prog_last;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [3:0]    q_in;
    logic [7:0]    op_sel;
    logic [3:0]    e_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] pc;

    contreg_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_last (prog_last),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .q_in      (q_in),
        .op_sel    (op_sel),
        .e_out     (e_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]    sel;
        logic [3:0]    e;
        logic [AW-1:0] pc;
        logic [3:0]    q;
        logic          busy;
        logic          done;
        logic          err;
    } exp_t;

    exp_t        tr[$];
    logic [11:0] prog [DEPTH];
    int          last_i;
    bit          loop_b;
    bit          q_frozen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] s, input logic [3:0] e, input logic b,
                                       input logic d, input logic er, input logic [AW-1:0] p);
        return 32'({s, e, b, d, er, p});
    endfunction

    // Counter/register block behaviour for one requested operation
    function automatic logic [3:0] ctr_next(input logic [3:0] q, input logic [2:0] op, input logic [3:0] e);
        if (q_frozen) return q;
        case (op)
            OP_HOLD: return q;
            OP_LOAD: return e;
            OP_UP:   return q + 4'd1;
            OP_DOWN: return q - 4'd1;
            OP_SHL:  return {q[2:0], 1'b0};
            OP_SHR:  return {1'b0, q[3:1]};
            OP_ROTL: return {q[2:0], q[3]};
            OP_CLR:  return 4'd0;
            default: return q;
        endcase
    endfunction

    task automatic push_issue(input logic [7:0] s, input logic [3:0] e, input int p, input logic [3:0] q);
        tr.push_back('{sel: s, e: e, pc: AW'(p), q: q, busy: 1'b1, done: 1'b0, err: 1'b0});
    endtask

    // Interprets the program instruction by instruction, producing the per-cycle trace
    task automatic model(input logic [3:0] q0, input int cap, output bit ended, output bit tmo, output int pcl);
        int          pcv;
        int          cnt;
        logic [3:0]  q;
        logic [11:0] w;
        logic [2:0]  op;
        logic [3:0]  arg;
        bit          un;
        pcv   = 0;
        q     = q0;
        ended = 0;
        tmo   = 0;
        tr.delete();
        while (!ended && tr.size() < cap) begin
            w   = prog[pcv];
            op  = w[11:9];
            un  = w[8];
            arg = w[7:4];
            cnt = int'(w[3:0]);
            if (!un) begin
                for (int k = 0; k <= cnt; k++) begin
                    push_issue(onehot8(op), arg, pcv, q);
                    q = ctr_next(q, op, arg);
                end
            end else begin
                for (int r = 0; r <= cnt; r++) begin
                    if (q == arg) begin
                        push_issue(8'h00, arg, pcv, q);
                        break;
                    end
                    push_issue(onehot8(op), arg, pcv, q);
                    q = ctr_next(q, op, arg);
                    if (r == cnt) tmo = 1;
                end
            end
            if (tmo) ended = 1;
            else if (pcv == last_i) begin
                if (loop_b) pcv = 0;
                else ended = 1;
            end else pcv++;
        end
        pcl = pcv;
        if (ended) tr.push_back('{sel: 8'h00, e: 4'h0, pc: AW'(pcv), q: q, busy: 1'b0, done: 1'b1, err: tmo});
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = prog[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] q0, input int stop_req, input bit inj);
        bit ended;
        bit tmo;
        bit stopped;
        int pcl;
        int stop_at;
        model(q0, loop_b ? 60 : 200, ended, tmo, pcl);
        stop_at = stop_req;
        if (!ended && (stop_at < 0 || stop_at >= tr.size())) stop_at = tr.size() - 1;
        stopped   = 0;
        prog_last = AW'(last_i);
        loop_en   = loop_b;
        stop      = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < tr.size() && !stopped; i++) begin
            q_in = tr[i].q;
            if (inj && i == 0) begin
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = ~prog[0];
                start     = 1'b1;
            end
            if (i == stop_at && tr[i].busy) begin
                stop    = 1'b1;
                stopped = 1;
            end
            #1;
            chk(tag, pk(op_sel, e_out, busy, done, err, pc),
                pk(tr[i].sel, tr[i].e, tr[i].busy, tr[i].done, tr[i].err, tr[i].pc));
            @(posedge clk); #1;
            prog_we = 1'b0;
            start   = 1'b0;
            stop    = 1'b0;
        end
        #1;
        if (stopped) begin
            chk({tag, "/stop"}, pk(op_sel, e_out, busy, done, err, '0), 32'd0);
        end else begin
            chk({tag, "/idle"}, pk(op_sel, e_out, busy, done, err, pc),
                pk(8'h00, 4'h0, 1'b0, 1'b0, tmo, AW'(pcl)));
            @(posedge clk); #2;
            chk({tag, "/sticky"}, pk(op_sel, e_out, busy, done, err, pc),
                pk(8'h00, 4'h0, 1'b0, 1'b0, tmo, AW'(pcl)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sa;
        clr       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_last = '0;
        start     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        q_in      = 4'h0;
        q_frozen  = 0;
        loop_b    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", pk(op_sel, e_out, busy, done, err, pc), 32'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        prog[0] = {OP_LOAD, 1'b0, 4'd5, 4'd0};
        prog[1] = {OP_UP, 1'b0, 4'd0, 4'd3};
        last_i  = 1;
        load_prog(2);
        run("timed", 4'd0, -1, 0);

        prog[0] = {OP_UP, 1'b1, 4'd9, 4'd15};
        last_i  = 0;
        load_prog(1);
        run("until", 4'd0, -1, 0);

        prog[0]  = {OP_UP, 1'b1, 4'd9, 4'd2};
        q_frozen = 1;
        load_prog(1);
        run("timeout", 4'd0, -1, 0);
        q_frozen = 0;

        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        chk("start_stop", pk(op_sel, e_out, busy, done, err, pc), pk(8'h00, 4'h0, 1'b0, 1'b0, 1'b1, '0));
        @(posedge clk); #2;
        chk("start_stop2", 32'(busy), 32'd0);
        clr = 1'b1;
        #1;
        chk("clr_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;

        prog[0] = {OP_UP, 1'b0, 4'd3, 4'd1};
        last_i  = 0;
        loop_b  = 1;
        load_prog(1);
        run("loop", 4'd0, 15, 0);
        loop_b = 0;

        prog[0] = {OP_LOAD, 1'b0, 4'd7, 4'd1};
        prog[1] = {OP_DOWN, 1'b0, 4'd2, 4'd2};
        prog[2] = {OP_SHL, 1'b0, 4'd1, 4'd0};
        last_i  = 2;
        load_prog(3);
        run("inject", 4'd3, -1, 1);
        run("inject_rerun", 4'd3, -1, 0);

        prog[0] = {OP_UP, 1'b0, 4'd0, 4'd15};
        last_i  = 0;
        load_prog(1);
        prog_last = '0;
        loop_en   = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_pre_clr", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        chk("clr_async", pk(op_sel, e_out, busy, done, err, pc), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("clr_idle", pk(op_sel, e_out, busy, done, err, pc), 32'd0);
        end

        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) prog[i] = 12'($urandom);
            last_i = n - 1;
            loop_b = ($urandom_range(0, 3) == 0);
            if (loop_b) sa = $urandom_range(2, 50);
            else sa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : -1;
            load_prog(n);
            run($sformatf("rand%0d", t), 4'($urandom), sa, ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
